i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares one i2c_master command/data interface among N_REQ requesters, e.g. si570_i2c_init, SFP module management and the temperature sensor poller, all on clk_50mhz.
- Grants round-robin and holds each grant for a whole I2C transaction, ending at the command that carries stop.
- Recovers an abandoned bus by injecting a stop command after an inactivity timeout.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 4096, idle cycles in GRANT before forced release (>=2)

Ports:
clk  in  1  system clock (clk_50mhz domain)
rst_n  in  1  synchronous active-low reset
req_cmd  in  N_REQ*12  per requester, packed {address[6:0],start,read,write,write_multiple,stop}; requester i at bits [12i+11:12i]
req_cmd_valid  in  N_REQ  command valid
req_cmd_ready  out  N_REQ  command accepted
req_wdata  in  N_REQ*8  write data
req_wdata_valid  in  N_REQ  write data valid
req_wdata_last  in  N_REQ  write data last
req_wdata_ready  out  N_REQ  write data accepted
req_rdata  out  8  read data, broadcast to all requesters
req_rdata_valid  out  N_REQ  read data valid, owner bit only
req_rdata_last  out  1  read data last
req_rdata_ready  in  N_REQ  read data ready
m_cmd  out  12  to i2c_master cmd_* (same packing)
m_cmd_valid  out  1
m_cmd_ready  in  1
m_data_in  out  8
m_data_in_valid  out  1
m_data_in_last  out  1
m_data_in_ready  in  1
m_data_out  in  8
m_data_out_valid  in  1
m_data_out_last  in  1
m_data_out_ready  out  1
m_busy  in  1  i2c_master busy
grant  out  N_REQ  one-hot current owner, registered
timeout_pulse  out  1  one-cycle pulse on forced release

Behaviour:
- States: IDLE, GRANT, DRAIN, INJECT_STOP. The owner index and grant are registered; all datapath muxing is combinational from the registered owner.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, grant=0, rr pointer=0, timeout counter=0, timeout_pulse=0.
  - All *_valid and *_ready outputs are 0, except m_data_out_ready=1.
  - Applies mid-transaction as well; i2c_master is reset separately.
- IDLE:
  - If any req_cmd_valid is set, pick the first set bit at or after the rr pointer, wrapping modulo N_REQ.
  - Next cycle: state=GRANT, grant=onehot(winner), rr pointer=winner+1 mod N_REQ.
  - No command is accepted in the arbitration cycle, so latency from first req_cmd_valid to m_cmd_valid is 1 cycle.
- GRANT, owner k:
  - Command path: m_cmd=req_cmd[k], m_cmd_valid=req_cmd_valid[k], req_cmd_ready[k]=m_cmd_ready.
  - Write path: wdata, valid and last pass straight through in the same way.
  - Read path: req_rdata_valid[k]=m_data_out_valid, m_data_out_ready=req_rdata_ready[k].
  - Non-owners see ready=0 and rdata_valid=0. Fields are not checked; they pass through unmodified.
  - When a command with stop=1 completes its handshake: state goes to DRAIN.
  - Timeout counter: cleared on any owner cmd, wdata or rdata handshake, otherwise increments. When it reaches TIMEOUT-1 with no handshake that cycle: state goes to INJECT_STOP.
  - If a stop handshake and the timeout fall in the same cycle, the stop wins (DRAIN, no pulse).
- DRAIN:
  - All requester readies are 0; read data still routes to the owner.
  - When m_busy=0: state=IDLE, grant=0.
- INJECT_STOP:
  - Drive m_cmd = {7'd0,start=0,read=0,write=0,write_multiple=0,stop=1} with m_cmd_valid=1; hold m_data_in_valid=0 and m_data_out_ready=1 (discard).
  - On m_cmd_ready: pulse timeout_pulse, state=DRAIN. The owner bit stays in grant until DRAIN exits.
- Outside GRANT and DRAIN: m_cmd_valid=0 except in INJECT_STOP, m_data_in_valid=0, m_data_out_ready=1 (stray read bytes are dropped).
- A single requester re-requesting wins again after one IDLE cycle. Fairness: with all requesters requesting, each gets exactly one transaction per N_REQ grants.
- Timeout counter width is $clog2(TIMEOUT) bits and it saturates; wrap is not allowed.

Decomposition:
- Package i2c_arb_pkg holds:
  - CMD_W=12 and the field offsets (CMD_STOP=0, CMD_WRM=1, CMD_WR=2, CMD_RD=3, CMD_START=4, CMD_ADDR=5..11).
  - The state enum {IDLE,GRANT,DRAIN,INJECT_STOP}.
- Sub-module rr_pick: combinational. Takes request vector and pointer, returns one-hot winner plus a valid flag. It is reused by future arbiters.

Test Plan:
- Only req0 sends start/write, 2 data bytes, then a write+stop command. -> grant=0001 one cycle after valid, bytes appear on m_data_in in order, DRAIN after the stop, IDLE once m_busy=0.
- All 4 requesters assert valid simultaneously from reset, each doing a one-command stop transaction. -> grant sequence 0001, 0010, 0100, 1000, then 0001 again.
- Owner 2 issues start/read/stop, master returns 0xA5 with last. -> req_rdata=0xA5, req_rdata_valid=0100 only, other requesters' ready stays 0.
- Owner 1 issues start/write, then stays idle for TIMEOUT=16 cycles. -> m_cmd=stop-only with m_cmd_valid at cycle 16, timeout_pulse for one cycle after m_cmd_ready, then IDLE.
- Stop handshake coincides with the TIMEOUT-1 count. -> DRAIN, timeout_pulse stays 0.
- rst_n=0 during GRANT with a pending write. -> next cycle grant=0, all readies 0, m_data_out_ready=1; after release the next grant starts from requester 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and command-word layout for the I2C bus arbiter.
// The command word layout matches the i2c_master cmd_* bundle.
package i2c_arb_pkg;

    localparam int CMD_W      = 12;
    localparam int CMD_STOP   = 0;
    localparam int CMD_WRM    = 1;
    localparam int CMD_WR     = 2;
    localparam int CMD_RD     = 3;
    localparam int CMD_START  = 4;
    localparam int CMD_ADDR   = 5;
    localparam int CMD_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT       = 2'd1,
        DRAIN       = 2'd2,
        INJECT_STOP = 2'd3
    } arb_state_e;

    // Bare stop command used to close an abandoned transaction.
    function automatic logic [CMD_W-1:0] stop_only_cmd();
        logic [CMD_W-1:0] c;
        c           = {CMD_W{1'b0}};
        c[CMD_STOP] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and i2c_master-side handshake bundle of the bus arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface i2c_bus_arbiter_if #(parameter int N_REQ = 4);

    logic [N_REQ*12-1:0] req_cmd;
    logic [N_REQ-1:0]    req_cmd_valid;
    logic [N_REQ-1:0]    req_cmd_ready;
    logic [N_REQ*8-1:0]  req_wdata;
    logic [N_REQ-1:0]    req_wdata_valid;
    logic [N_REQ-1:0]    req_wdata_last;
    logic [N_REQ-1:0]    req_wdata_ready;
    logic [7:0]          req_rdata;
    logic [N_REQ-1:0]    req_rdata_valid;
    logic                req_rdata_last;
    logic [N_REQ-1:0]    req_rdata_ready;
    logic [11:0]         m_cmd;
    logic                m_cmd_valid;
    logic                m_cmd_ready;
    logic [7:0]          m_data_in;
    logic                m_data_in_valid;
    logic                m_data_in_last;
    logic                m_data_in_ready;
    logic [7:0]          m_data_out;
    logic                m_data_out_valid;
    logic                m_data_out_last;
    logic                m_data_out_ready;
    logic                m_busy;

    modport master (
        input  req_cmd, req_cmd_valid, req_wdata, req_wdata_valid, req_wdata_last,
        input  req_rdata_ready, m_cmd_ready, m_data_in_ready,
        input  m_data_out, m_data_out_valid, m_data_out_last, m_busy,
        output req_cmd_ready, req_wdata_ready, req_rdata, req_rdata_valid, req_rdata_last,
        output m_cmd, m_cmd_valid, m_data_in, m_data_in_valid, m_data_in_last,
        output m_data_out_ready
    );

    modport slave (
        output req_cmd, req_cmd_valid, req_wdata, req_wdata_valid, req_wdata_last,
        output req_rdata_ready, m_cmd_ready, m_data_in_ready,
        output m_data_out, m_data_out_valid, m_data_out_last, m_busy,
        input  req_cmd_ready, req_wdata_ready, req_rdata, req_rdata_valid, req_rdata_last,
        input  m_cmd, m_cmd_valid, m_data_in, m_data_in_valid, m_data_in_last,
        input  m_data_out_ready
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N. Returns index, one-hot and a valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        w_cand  = {IW{1'b0}};
        o_idx   = {IW{1'b0}};
        o_valid = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            w_cand  = IW'((int'(i_ptr) + off) % N);
            o_idx   = i_req[w_cand] ? w_cand : o_idx;
            o_valid = o_valid | i_req[w_cand];
        end
        o_onehot = o_valid ? (N'(1) << o_idx) : {N{1'b0}};
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master among N_REQ requesters; a grant
// lasts a whole transaction and an abandoned bus is closed with a forced stop.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_bus_arbiter_if.master  bus,
    output logic [N_REQ-1:0]   grant,
    output logic               timeout_pulse
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};

    arb_state_e         r_state;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_rr_ptr;
    logic [N_REQ-1:0]   r_grant;
    logic [TW-1:0]      r_tmo_cnt;
    logic               r_tmo_pulse;

    arb_state_e         w_state_nxt;
    logic [IW-1:0]      w_owner_nxt;
    logic [IW-1:0]      w_rr_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [TW-1:0]      w_tmo_nxt;
    logic               w_pulse_nxt;

    logic [N_REQ-1:0]   w_pick_oh;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_valid;

    logic [CMD_W-1:0]   w_own_cmd;
    logic [7:0]         w_own_wdata;
    logic               w_own_wlast;
    logic               w_own_cmd_valid;
    logic               w_own_wvalid;
    logic               w_own_rready;
    logic               w_cmd_hs;
    logic               w_stop_hs;
    logic               w_any_hs;

    logic [CMD_W-1:0]   w_m_cmd;
    logic               w_m_cmd_valid;
    logic               w_m_data_in_valid;
    logic               w_m_data_in_last;
    logic               w_m_data_out_ready;
    logic [N_REQ-1:0]   w_req_cmd_ready;
    logic [N_REQ-1:0]   w_req_wdata_ready;
    logic [N_REQ-1:0]   w_req_rdata_valid;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .i_req    (bus.req_cmd_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Select the registered owner's command and write lanes.
    always_comb begin
        w_own_cmd   = {CMD_W{1'b0}};
        w_own_wdata = 8'd0;
        w_own_wlast = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_own_cmd   = (r_owner == IW'(i)) ? bus.req_cmd[i*CMD_W +: CMD_W] : w_own_cmd;
            w_own_wdata = (r_owner == IW'(i)) ? bus.req_wdata[i*8 +: 8]       : w_own_wdata;
            w_own_wlast = (r_owner == IW'(i)) ? bus.req_wdata_last[i]         : w_own_wlast;
        end
    end

    assign w_own_cmd_valid = |(bus.req_cmd_valid   & r_grant);
    assign w_own_wvalid    = |(bus.req_wdata_valid & r_grant);
    assign w_own_rready    = |(bus.req_rdata_ready & r_grant);
    assign w_cmd_hs        = w_own_cmd_valid & bus.m_cmd_ready;
    assign w_stop_hs       = w_cmd_hs & w_own_cmd[CMD_STOP];
    assign w_any_hs        = w_cmd_hs | (w_own_wvalid & bus.m_data_in_ready)
                           | (bus.m_data_out_valid & w_own_rready);

    // Next-state and datapath routing from the registered owner.
    always_comb begin
        w_state_nxt        = r_state;
        w_owner_nxt        = r_owner;
        w_rr_nxt           = r_rr_ptr;
        w_grant_nxt        = r_grant;
        w_tmo_nxt          = {TW{1'b0}};
        w_pulse_nxt        = 1'b0;
        w_m_cmd            = {CMD_W{1'b0}};
        w_m_cmd_valid      = 1'b0;
        w_m_data_in_valid  = 1'b0;
        w_m_data_in_last   = 1'b0;
        w_m_data_out_ready = 1'b1;
        w_req_cmd_ready    = {N_REQ{1'b0}};
        w_req_wdata_ready  = {N_REQ{1'b0}};
        w_req_rdata_valid  = {N_REQ{1'b0}};
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_grant_nxt = w_pick_oh;
                    w_rr_nxt    = (w_pick_idx == IW'(N_REQ - 1)) ? {IW{1'b0}} : w_pick_idx + IW'(1);
                end else begin
                    w_grant_nxt = {N_REQ{1'b0}};
                end
            end
            GRANT: begin
                w_m_cmd            = w_own_cmd;
                w_m_cmd_valid      = w_own_cmd_valid;
                w_req_cmd_ready    = r_grant & {N_REQ{bus.m_cmd_ready}};
                w_m_data_in_valid  = w_own_wvalid;
                w_m_data_in_last   = w_own_wlast;
                w_req_wdata_ready  = r_grant & {N_REQ{bus.m_data_in_ready}};
                w_req_rdata_valid  = r_grant & {N_REQ{bus.m_data_out_valid}};
                w_m_data_out_ready = w_own_rready;
                // A stop handshake takes precedence over an expiring timeout.
                if (w_stop_hs) begin
                    w_state_nxt = DRAIN;
                end else if (w_any_hs) begin
                    w_tmo_nxt = {TW{1'b0}};
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = INJECT_STOP;
                end else begin
                    w_tmo_nxt = (r_tmo_cnt == TMO_MAX) ? r_tmo_cnt : r_tmo_cnt + TW'(1);
                end
            end
            DRAIN: begin
                w_req_rdata_valid  = r_grant & {N_REQ{bus.m_data_out_valid}};
                w_m_data_out_ready = w_own_rready;
                if (!bus.m_busy) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = {N_REQ{1'b0}};
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            INJECT_STOP: begin
                w_m_cmd       = stop_only_cmd();
                w_m_cmd_valid = 1'b1;
                if (bus.m_cmd_ready) begin
                    w_state_nxt = DRAIN;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_state_nxt = INJECT_STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = {N_REQ{1'b0}};
            end
        endcase
    end

    // State, owner, pointer, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= {IW{1'b0}};
            r_rr_ptr    <= {IW{1'b0}};
            r_grant     <= {N_REQ{1'b0}};
            r_tmo_cnt   <= {TW{1'b0}};
            r_tmo_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant     <= w_grant_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_tmo_pulse <= w_pulse_nxt;
        end
    end

    assign grant                = r_grant;
    assign timeout_pulse        = r_tmo_pulse;
    assign bus.m_cmd            = w_m_cmd;
    assign bus.m_cmd_valid      = w_m_cmd_valid;
    assign bus.m_data_in        = w_own_wdata;
    assign bus.m_data_in_valid  = w_m_data_in_valid;
    assign bus.m_data_in_last   = w_m_data_in_last;
    assign bus.m_data_out_ready = w_m_data_out_ready;
    assign bus.req_cmd_ready    = w_req_cmd_ready;
    assign bus.req_wdata_ready  = w_req_wdata_ready;
    assign bus.req_rdata        = bus.m_data_out;
    assign bus.req_rdata_valid  = w_req_rdata_valid;
    assign bus.req_rdata_last   = bus.m_data_out_last;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed table, hand sequences for
// timeout/reset corners, and randomized traffic against a transaction-level model.
module tb_i2c_bus_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [N-1:0] grant;
    logic       timeout_pulse;
    int         n_pass = 0;
    int         n_total = 0;
    bit         chk_model = 1'b0;

    // Reference model: owner (-1 none), draining / injecting flags, quiet count.
    int mo, mrr, mq;
    bit md, mi, mp;

    i2c_bus_arbiter_if #(.N_REQ(N)) bif();

    i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .grant(grant), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [11:0] mk(input logic [6:0] a, input bit st, input bit rd,
                                       input bit wr, input bit wm, input bit sp);
        return {a, st, rd, wr, wm, sp};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic set_cmd(input int i, input logic [11:0] c, input bit v);
        bif.req_cmd[i*12 +: 12] = c;
        bif.req_cmd_valid[i]    = v;
    endtask

    task automatic clear_inputs();
        bif.req_cmd = '0;  bif.req_cmd_valid = '0;
        bif.req_wdata = '0; bif.req_wdata_valid = '0; bif.req_wdata_last = '0;
        bif.req_rdata_ready = '0;
        bif.m_cmd_ready = 1'b0; bif.m_data_in_ready = 1'b0;
        bif.m_data_out = 8'd0; bif.m_data_out_valid = 1'b0; bif.m_data_out_last = 1'b0;
        bif.m_busy = 1'b0;
    endtask

    task automatic model_check();
        logic [3:0] eg;
        logic [1:0] ow;
        bit g, route, emcv;
        eg    = (mo >= 0) ? 4'(1 << mo) : 4'd0;
        ow    = (mo >= 0) ? 2'(mo) : 2'd0;
        g     = (mo >= 0) && !md && !mi;
        route = g || md;
        emcv  = g ? bif.req_cmd_valid[ow] : mi;
        chk("rnd_grant", 32'(grant), 32'(eg));
        chk("rnd_pulse", 32'(timeout_pulse), 32'(mp));
        chk("rnd_mcmd_valid", 32'(bif.m_cmd_valid), 32'(emcv));
        if (emcv) chk("rnd_mcmd", 32'(bif.m_cmd), g ? 32'(bif.req_cmd[ow*12 +: 12]) : 32'h001);
        chk("rnd_cmd_ready", 32'(bif.req_cmd_ready), (g && bif.m_cmd_ready) ? 32'(eg) : 32'd0);
        chk("rnd_wready", 32'(bif.req_wdata_ready), (g && bif.m_data_in_ready) ? 32'(eg) : 32'd0);
        chk("rnd_din_valid", 32'(bif.m_data_in_valid), g ? 32'(bif.req_wdata_valid[ow]) : 32'd0);
        if (g && bif.req_wdata_valid[ow]) begin
            chk("rnd_din", 32'(bif.m_data_in), 32'(bif.req_wdata[ow*8 +: 8]));
            chk("rnd_din_last", 32'(bif.m_data_in_last), 32'(bif.req_wdata_last[ow]));
        end
        chk("rnd_rvalid", 32'(bif.req_rdata_valid), (route && bif.m_data_out_valid) ? 32'(eg) : 32'd0);
        chk("rnd_dout_ready", 32'(bif.m_data_out_ready), route ? 32'(bif.req_rdata_ready[ow]) : 32'd1);
        chk("rnd_rdata", 32'(bif.req_rdata), 32'(bif.m_data_out));
    endtask

    task automatic model_step();
        logic [1:0] ow;
        bit g, cmd_hs, any_hs, found;
        ow = (mo >= 0) ? 2'(mo) : 2'd0;
        g  = (mo >= 0) && !md && !mi;
        mp = 1'b0;
        if (!rst_n) begin
            mo = -1; md = 0; mi = 0; mrr = 0; mq = 0;
        end else if (mo < 0) begin
            found = 0;
            for (int off = 0; off < N; off++) begin
                if (!found && bif.req_cmd_valid[(mrr + off) % N]) begin
                    found = 1; mo = (mrr + off) % N;
                end
            end
            if (found) begin mrr = (mo + 1) % N; mq = 0; end
        end else if (g) begin
            cmd_hs = bif.req_cmd_valid[ow] && bif.m_cmd_ready;
            any_hs = cmd_hs || (bif.req_wdata_valid[ow] && bif.m_data_in_ready)
                     || (bif.m_data_out_valid && bif.req_rdata_ready[ow]);
            if (cmd_hs && bif.req_cmd[ow*12]) md = 1;
            else if (any_hs) mq = 0;
            else begin
                mq++;
                if (mq == TMO) mi = 1;
            end
        end else if (mi) begin
            if (bif.m_cmd_ready) begin mi = 0; md = 1; mp = 1; end
        end else if (md && !bif.m_busy) begin
            md = 0; mo = -1;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clock();
        if (chk_model) model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) begin settle(); clock(); end
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] vld;
        logic [3:0] eg;
        logic       emcv;
        logic [3:0] ecr;
    } rr_vec_t;

    rr_vec_t tbl[16];
    logic [11:0] c1, c2;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;

        // Reset state
        reset_dut();
        settle();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_pulse", 32'(timeout_pulse), 32'd0);
        chk("rst_mcv", 32'(bif.m_cmd_valid), 32'd0);
        chk("rst_dout_ready", 32'(bif.m_data_out_ready), 32'd1);

        // Single requester write transaction
        c1 = mk(7'h50, 1, 0, 1, 0, 0);
        c2 = mk(7'h50, 0, 0, 1, 0, 1);
        set_cmd(0, c1, 1); bif.m_cmd_ready = 1; bif.m_data_in_ready = 1; bif.m_busy = 1;
        settle();
        chk("t1_arb_grant", 32'(grant), 32'd0);
        chk("t1_arb_mcv", 32'(bif.m_cmd_valid), 32'd0);
        clock(); settle();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_mcv", 32'(bif.m_cmd_valid), 32'd1);
        chk("t1_mcmd", 32'(bif.m_cmd), 32'(c1));
        chk("t1_cready", 32'(bif.req_cmd_ready), 32'h1);
        clock();
        set_cmd(0, c1, 0);
        bif.req_wdata[7:0] = 8'h11; bif.req_wdata_valid[0] = 1; bif.req_wdata_last[0] = 0;
        settle();
        chk("t1_b0", 32'(bif.m_data_in), 32'h11);
        chk("t1_b0_valid", 32'(bif.m_data_in_valid), 32'd1);
        chk("t1_b0_last", 32'(bif.m_data_in_last), 32'd0);
        chk("t1_wready", 32'(bif.req_wdata_ready), 32'h1);
        clock();
        bif.req_wdata[7:0] = 8'h22; bif.req_wdata_last[0] = 1;
        settle();
        chk("t1_b1", 32'(bif.m_data_in), 32'h22);
        chk("t1_b1_last", 32'(bif.m_data_in_last), 32'd1);
        clock();
        bif.req_wdata_valid[0] = 0; bif.req_wdata_last[0] = 0;
        set_cmd(0, c2, 1);
        settle();
        chk("t1_stop_mcmd", 32'(bif.m_cmd), 32'(c2));
        clock();
        set_cmd(0, c2, 0); bif.req_wdata_valid[0] = 1;
        settle();
        chk("t1_drain_grant", 32'(grant), 32'h1);
        chk("t1_drain_wready", 32'(bif.req_wdata_ready), 32'd0);
        chk("t1_drain_dinv", 32'(bif.m_data_in_valid), 32'd0);
        chk("t1_drain_mcv", 32'(bif.m_cmd_valid), 32'd0);
        clock();
        bif.m_busy = 0; bif.req_wdata_valid[0] = 0;
        settle();
        chk("t1_drain_hold", 32'(grant), 32'h1);
        clock(); settle();
        chk("t1_idle", 32'(grant), 32'd0);
        clock();

        // Round-robin fairness from reset, table-driven
        tbl[0]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0001, 1'b1, 4'b0001};
        tbl[2]  = '{4'b1110, 4'b0001, 1'b0, 4'b0000};
        tbl[3]  = '{4'b1110, 4'b0000, 1'b0, 4'b0000};
        tbl[4]  = '{4'b1110, 4'b0010, 1'b1, 4'b0010};
        tbl[5]  = '{4'b1100, 4'b0010, 1'b0, 4'b0000};
        tbl[6]  = '{4'b1100, 4'b0000, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1100, 4'b0100, 1'b1, 4'b0100};
        tbl[8]  = '{4'b1000, 4'b0100, 1'b0, 4'b0000};
        tbl[9]  = '{4'b1000, 4'b0000, 1'b0, 4'b0000};
        tbl[10] = '{4'b1000, 4'b1000, 1'b1, 4'b1000};
        tbl[11] = '{4'b0001, 4'b1000, 1'b0, 4'b0000};
        tbl[12] = '{4'b0001, 4'b0000, 1'b0, 4'b0000};
        tbl[13] = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
        tbl[14] = '{4'b0000, 4'b0001, 1'b0, 4'b0000};
        tbl[15] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
        reset_dut();
        for (int i = 0; i < N; i++) set_cmd(i, mk(7'(8'h20 + i), 1, 0, 1, 0, 1), 0);
        bif.m_cmd_ready = 1;
        for (int r = 0; r < 16; r++) begin
            bif.req_cmd_valid = tbl[r].vld;
            settle();
            chk($sformatf("rr%0d_grant", r), 32'(grant), 32'(tbl[r].eg));
            chk($sformatf("rr%0d_mcv", r), 32'(bif.m_cmd_valid), 32'(tbl[r].emcv));
            chk($sformatf("rr%0d_cready", r), 32'(bif.req_cmd_ready), 32'(tbl[r].ecr));
            clock();
        end

        // Owner 2 read, data broadcast and routed to owner only
        reset_dut();
        set_cmd(2, mk(7'h48, 1, 1, 0, 0, 1), 1); bif.m_cmd_ready = 1; bif.m_busy = 1;
        settle(); clock(); settle();
        chk("t3_grant", 32'(grant), 32'h4);
        chk("t3_cready", 32'(bif.req_cmd_ready), 32'h4);
        clock();
        bif.req_cmd_valid = 4'hF; bif.req_wdata_valid = 4'hF; bif.m_data_in_ready = 1;
        bif.m_data_out = 8'hA5; bif.m_data_out_valid = 1; bif.m_data_out_last = 1;
        bif.req_rdata_ready = 4'hF;
        settle();
        chk("t3_rdata", 32'(bif.req_rdata), 32'hA5);
        chk("t3_rvalid", 32'(bif.req_rdata_valid), 32'h4);
        chk("t3_rlast", 32'(bif.req_rdata_last), 32'd1);
        chk("t3_cready_drain", 32'(bif.req_cmd_ready), 32'd0);
        chk("t3_wready_drain", 32'(bif.req_wdata_ready), 32'd0);
        chk("t3_dout_ready", 32'(bif.m_data_out_ready), 32'd1);
        clock();
        bif.req_rdata_ready = 4'b1011;
        settle();
        chk("t3_dout_ready_owner", 32'(bif.m_data_out_ready), 32'd0);
        clock();
        clear_inputs();
        settle(); clock(); settle();
        chk("t3_idle", 32'(grant), 32'd0);

        // Owner 1 abandons the bus: forced stop after TMO quiet cycles
        reset_dut();
        set_cmd(1, mk(7'h22, 1, 0, 1, 0, 0), 1); bif.m_cmd_ready = 1; bif.m_busy = 1;
        settle(); clock(); settle();
        chk("t4_grant", 32'(grant), 32'h2);
        clock();
        set_cmd(1, mk(7'h22, 1, 0, 1, 0, 0), 0);
        for (int q = 0; q < TMO; q++) begin
            settle();
            chk($sformatf("t4_quiet%0d_mcv", q), 32'(bif.m_cmd_valid), 32'd0);
            clock();
        end
        bif.m_cmd_ready = 0;
        settle();
        chk("t4_inj_mcv", 32'(bif.m_cmd_valid), 32'd1);
        chk("t4_inj_mcmd", 32'(bif.m_cmd), 32'h001);
        chk("t4_inj_pulse", 32'(timeout_pulse), 32'd0);
        chk("t4_inj_dinv", 32'(bif.m_data_in_valid), 32'd0);
        chk("t4_inj_dout_ready", 32'(bif.m_data_out_ready), 32'd1);
        clock();
        bif.m_cmd_ready = 1;
        settle();
        chk("t4_inj_hold", 32'(bif.m_cmd_valid), 32'd1);
        clock();
        bif.m_busy = 0;
        settle();
        chk("t4_pulse", 32'(timeout_pulse), 32'd1);
        chk("t4_drain_grant", 32'(grant), 32'h2);
        chk("t4_drain_mcv", 32'(bif.m_cmd_valid), 32'd0);
        clock(); settle();
        chk("t4_pulse_end", 32'(timeout_pulse), 32'd0);
        chk("t4_idle", 32'(grant), 32'd0);

        // Stop handshake coinciding with the last timeout count
        reset_dut();
        set_cmd(3, mk(7'h30, 1, 0, 1, 0, 0), 1); bif.m_cmd_ready = 1; bif.m_busy = 1;
        settle(); clock(); settle();
        chk("t5_grant", 32'(grant), 32'h8);
        clock();
        set_cmd(3, mk(7'h30, 1, 0, 1, 0, 0), 0);
        repeat (TMO - 1) begin settle(); clock(); end
        set_cmd(3, mk(7'h30, 0, 0, 1, 0, 1), 1);
        settle();
        chk("t5_stop_mcv", 32'(bif.m_cmd_valid), 32'd1);
        clock();
        set_cmd(3, mk(7'h30, 0, 0, 1, 0, 1), 0);
        settle();
        chk("t5_drain_grant", 32'(grant), 32'h8);
        chk("t5_drain_mcv", 32'(bif.m_cmd_valid), 32'd0);
        chk("t5_no_pulse", 32'(timeout_pulse), 32'd0);
        clock();
        bif.m_busy = 0;
        settle();
        chk("t5_no_pulse2", 32'(timeout_pulse), 32'd0);
        clock(); settle();
        chk("t5_idle", 32'(grant), 32'd0);

        // Reset in the middle of a pending write
        reset_dut();
        set_cmd(0, mk(7'h50, 1, 0, 1, 0, 0), 1); bif.m_cmd_ready = 1; bif.m_busy = 1;
        settle(); clock(); settle();
        chk("t6_grant", 32'(grant), 32'h1);
        clock();
        set_cmd(0, mk(7'h50, 1, 0, 1, 0, 0), 0);
        bif.req_wdata_valid[0] = 1; bif.m_data_in_ready = 0; rst_n = 0;
        settle(); clock();
        bif.req_cmd_valid = 4'hF; bif.m_data_in_ready = 1;
        bif.m_data_out_valid = 1; bif.req_rdata_ready = 4'h0;
        settle();
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_cready", 32'(bif.req_cmd_ready), 32'd0);
        chk("t6_rst_wready", 32'(bif.req_wdata_ready), 32'd0);
        chk("t6_rst_mcv", 32'(bif.m_cmd_valid), 32'd0);
        chk("t6_rst_dinv", 32'(bif.m_data_in_valid), 32'd0);
        chk("t6_rst_rvalid", 32'(bif.req_rdata_valid), 32'd0);
        chk("t6_rst_dout_ready", 32'(bif.m_data_out_ready), 32'd1);
        rst_n = 1;
        clock(); settle();
        chk("t6_restart_grant", 32'(grant), 32'h1);
        clock();

        // Randomized traffic against the reference model
        reset_dut();
        chk_model = 1'b1;
        for (int seg = 0; seg < 16; seg++) begin
            int dens;
            dens = (seg % 4 == 3) ? 0 : int'($urandom_range(1, 4));
            for (int cyc = 0; cyc < 200; cyc++) begin
                for (int i = 0; i < N; i++) begin
                    logic [11:0] c;
                    c = 12'($urandom);
                    c[0] = ($urandom_range(0, 3) == 0);
                    set_cmd(i, c, $urandom_range(0, 7) < dens);
                    bif.req_wdata[i*8 +: 8] = 8'($urandom);
                    bif.req_wdata_valid[i]  = $urandom_range(0, 7) < dens;
                    bif.req_wdata_last[i]   = 1'($urandom);
                    bif.req_rdata_ready[i]  = 1'($urandom);
                end
                bif.m_cmd_ready      = $urandom_range(0, 3) != 0;
                bif.m_data_in_ready  = $urandom_range(0, 3) != 0;
                bif.m_data_out       = 8'($urandom);
                bif.m_data_out_valid = $urandom_range(0, 7) < dens;
                bif.m_data_out_last  = 1'($urandom);
                bif.m_busy           = 1'($urandom);
                if (seg == 8 && cyc == 100) rst_n = 1'b0;
                else rst_n = 1'b1;
                settle();
                clock();
            end
        end
        chk_model = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
